// File: rtl/multicycle_controller.sv
// multicycle_controller
// Control unit for the multi-cycle 8-bit CPU. One registered state plus a
// registered control word that is decoded from the state being entered, so
// every datapath enable is glitch-free and valid for the whole cycle.
//
// Build option: define CTRL_ILLEGAL_TRAP_EN to send undefined opcodes
// (7..14) to HALT and raise a sticky illegalOp. Without it they execute as
// a 3-cycle NOP and illegalOp is tied low.
//
// state | meaning
// sIf   | fetch IR byte from M[PC], PC += 1
// sDf   | fetch DI byte from M[PC], PC += 1
// sDec  | load TR, load A from R[IR1:0], pick next state by opcode/flags
// sMrd  | LDA: R[IR1:0] <= M[TR]
// sMwr  | STA: M[TR] <= A
// sJmp  | PC <= TR (jump or taken branch)
// sRb   | load B from R[IR3:2]
// sEx   | ALU operation, capture result and flags
// sWb   | R[IR1:0] <= ALU result
// sHalt | stopped until reset

module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] IrToCU,
    input  logic [4:0] DiToCU,
    input  logic [2:0] CznToCU,
    output logic       pcInc,
    output logic       pcLoadEn,
    output logic       diLoadEn,
    output logic       irLoadEn,
    output logic       trLoadEn,
    output logic       PcOrTR,
    output logic       memReadEn,
    output logic       memWriteEn,
    output logic       reg1Or2,
    output logic       regOrMem,
    output logic       accWriteEn,
    output logic       aLoadEn,
    output logic       bLoadEn,
    output logic       RegAOr0,
    output logic       RegBOr0,
    output logic [2:0] aluOp,
    output logic       aluResLoadEn,
    output logic       cznLoadEn,
    output logic       halted,
    output logic       illegalOp
);

    typedef enum logic [STATE_W-1:0] {
        sIf, sDf, sDec, sMrd, sMwr, sJmp, sRb, sEx, sWb, sHalt
    } stateT;

    typedef struct packed {
        logic       pcInc;
        logic       pcLoadEn;
        logic       diLoadEn;
        logic       irLoadEn;
        logic       trLoadEn;
        logic       PcOrTR;
        logic       memReadEn;
        logic       memWriteEn;
        logic       reg1Or2;
        logic       regOrMem;
        logic       accWriteEn;
        logic       aLoadEn;
        logic       bLoadEn;
        logic       RegAOr0;
        logic       RegBOr0;
        logic [2:0] aluOp;
        logic       aluResLoadEn;
        logic       cznLoadEn;
        logic       halted;
    } ctrlT;

    stateT state;
    stateT nextState;
    ctrlT  ctrlQ;

    // Control word for a given state; di only matters for sEx
    function automatic ctrlT decodeOut(input stateT s, input logic [4:0] di);
        ctrlT c;
        c = '0;
        case (s)
            sIf: begin
                c.memReadEn = 1'b1;
                c.irLoadEn  = 1'b1;
                c.pcInc     = 1'b1;
            end
            sDf: begin
                c.memReadEn = 1'b1;
                c.diLoadEn  = 1'b1;
                c.pcInc     = 1'b1;
            end
            sDec: begin
                c.trLoadEn = 1'b1;
                c.aLoadEn  = 1'b1;
            end
            sMrd: begin
                c.PcOrTR     = 1'b1;
                c.memReadEn  = 1'b1;
                c.regOrMem   = 1'b1;
                c.accWriteEn = 1'b1;
            end
            sMwr: begin
                c.PcOrTR     = 1'b1;
                c.memWriteEn = 1'b1;
            end
            sJmp: c.pcLoadEn = 1'b1;
            sRb: begin
                c.reg1Or2 = 1'b1;
                c.bLoadEn = 1'b1;
            end
            sEx: begin
                c.aluOp        = di[2:0];
                c.RegAOr0      = di[3];
                c.RegBOr0      = di[4];
                c.aluResLoadEn = 1'b1;
                c.cznLoadEn    = 1'b1;
            end
            sWb:     c.accWriteEn = 1'b1;
            sHalt:   c.halted     = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state selection; branch flags are sampled while in sDec
    always_comb begin
        nextState = sIf;
        case (state)
            sIf:  nextState = sDf;
            sDf:  nextState = sDec;
            sDec: begin
                case (IrToCU)
                    4'd0:  nextState = sMrd;
                    4'd1:  nextState = sMwr;
                    4'd2:  nextState = sJmp;
                    4'd3:  nextState = CznToCU[1] ? sJmp : sIf;
                    4'd4:  nextState = CznToCU[2] ? sJmp : sIf;
                    4'd5:  nextState = CznToCU[0] ? sJmp : sIf;
                    4'd6:  nextState = sRb;
                    4'd15: nextState = sHalt;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default: nextState = sHalt;
`else
                    default: nextState = sIf;
`endif
                endcase
            end
            sRb:     nextState = sEx;
            sEx:     nextState = sWb;
            sHalt:   nextState = sHalt;
            default: nextState = sIf;
        endcase
    end

    // State and control-word registers; reset forces IF decode immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= sIf;
            ctrlQ <= decodeOut(sIf, 5'd0);
        end else begin
            state <= nextState;
            ctrlQ <= decodeOut(nextState, DiToCU);
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegalQ;

    // Sticky trap flag, set on the edge that leaves DEC for an undefined opcode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegalQ <= 1'b0;
        end else if (state == sDec && IrToCU >= 4'd7 && IrToCU <= 4'd14) begin
            illegalQ <= 1'b1;
        end
    end

    assign illegalOp = illegalQ;
`else
    assign illegalOp = 1'b0;
`endif

    assign pcInc        = ctrlQ.pcInc;
    assign pcLoadEn     = ctrlQ.pcLoadEn;
    assign diLoadEn     = ctrlQ.diLoadEn;
    assign irLoadEn     = ctrlQ.irLoadEn;
    assign trLoadEn     = ctrlQ.trLoadEn;
    assign PcOrTR       = ctrlQ.PcOrTR;
    assign memReadEn    = ctrlQ.memReadEn;
    assign memWriteEn   = ctrlQ.memWriteEn;
    assign reg1Or2      = ctrlQ.reg1Or2;
    assign regOrMem     = ctrlQ.regOrMem;
    assign accWriteEn   = ctrlQ.accWriteEn;
    assign aLoadEn      = ctrlQ.aLoadEn;
    assign bLoadEn      = ctrlQ.bLoadEn;
    assign RegAOr0      = ctrlQ.RegAOr0;
    assign RegBOr0      = ctrlQ.RegBOr0;
    assign aluOp        = ctrlQ.aluOp;
    assign aluResLoadEn = ctrlQ.aluResLoadEn;
    assign cznLoadEn    = ctrlQ.cznLoadEn;
    assign halted       = ctrlQ.halted;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
// Directed bench for multicycle_controller. Outputs are gathered into one
// 21-bit bus and compared at the falling edge against hand-written words:
// {pcInc pcLoadEn diLoadEn irLoadEn trLoadEn}_{PcOrTR memReadEn memWriteEn
//  reg1Or2 regOrMem}_{accWriteEn aLoadEn bLoadEn RegAOr0 RegBOr0}_{aluOp}_
// {aluResLoadEn cznLoadEn halted}
// Honors CTRL_ILLEGAL_TRAP_EN the same way as the design.

module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] IrToCU = 4'd0;
    logic [4:0] DiToCU = 5'd0;
    logic [2:0] CznToCU = 3'd0;
    logic pcInc, pcLoadEn, diLoadEn, irLoadEn, trLoadEn, PcOrTR, memReadEn;
    logic memWriteEn, reg1Or2, regOrMem, accWriteEn, aLoadEn, bLoadEn;
    logic RegAOr0, RegBOr0, aluResLoadEn, cznLoadEn, halted, illegalOp;
    logic [2:0] aluOp;

    int testsRun  = 0;
    int testsFail = 0;

    localparam logic [20:0] EXP_IF   = 21'b10010_01000_00000_000_000;
    localparam logic [20:0] EXP_DF   = 21'b10100_01000_00000_000_000;
    localparam logic [20:0] EXP_DEC  = 21'b00001_00000_01000_000_000;
    localparam logic [20:0] EXP_MRD  = 21'b00000_11001_10000_000_000;
    localparam logic [20:0] EXP_MWR  = 21'b00000_10100_00000_000_000;
    localparam logic [20:0] EXP_JMP  = 21'b01000_00000_00000_000_000;
    localparam logic [20:0] EXP_RB   = 21'b00000_00010_00100_000_000;
    localparam logic [20:0] EXP_EX0A = 21'b00000_00000_00010_010_110;
    localparam logic [20:0] EXP_EX15 = 21'b00000_00000_00001_101_110;
    localparam logic [20:0] EXP_WB   = 21'b00000_00000_10000_000_000;
    localparam logic [20:0] EXP_HALT = 21'b00000_00000_00000_000_001;

    logic [20:0] obsBus;
    assign obsBus = {pcInc, pcLoadEn, diLoadEn, irLoadEn, trLoadEn,
                     PcOrTR, memReadEn, memWriteEn, reg1Or2, regOrMem,
                     accWriteEn, aLoadEn, bLoadEn, RegAOr0, RegBOr0,
                     aluOp, aluResLoadEn, cznLoadEn, halted};

    multicycle_controller #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst),
        .IrToCU(IrToCU), .DiToCU(DiToCU), .CznToCU(CznToCU),
        .pcInc(pcInc), .pcLoadEn(pcLoadEn), .diLoadEn(diLoadEn),
        .irLoadEn(irLoadEn), .trLoadEn(trLoadEn), .PcOrTR(PcOrTR),
        .memReadEn(memReadEn), .memWriteEn(memWriteEn), .reg1Or2(reg1Or2),
        .regOrMem(regOrMem), .accWriteEn(accWriteEn), .aLoadEn(aLoadEn),
        .bLoadEn(bLoadEn), .RegAOr0(RegAOr0), .RegBOr0(RegBOr0),
        .aluOp(aluOp), .aluResLoadEn(aluResLoadEn), .cznLoadEn(cznLoadEn),
        .halted(halted), .illegalOp(illegalOp)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare the current cycle's outputs, then move to the next cycle
    task automatic expectState(input string tag, input logic [20:0] exp);
        checkVal(tag, {11'd0, obsBus}, {11'd0, exp});
        @(negedge clk);
    endtask

    task automatic setInstr(input logic [7:0] ir, input logic [4:0] di, input logic [2:0] czn);
        IrToCU  = ir[7:4];
        DiToCU  = di;
        CznToCU = czn;
    endtask

    initial begin
        // Reset held across edges: IF decode, no halt/illegal
        @(negedge clk);
        @(negedge clk);
        checkVal("reset.bus", {11'd0, obsBus}, {11'd0, EXP_IF});
        checkVal("reset.illegal", {31'd0, illegalOp}, 32'd0);
        rst = 1'b1;

        // LDA R1 <- M[0x20]: IF DF DEC MRD, IF again on cycle 5
        setInstr(8'h01, 5'h00, 3'b000);
        expectState("lda.if", EXP_IF);
        expectState("lda.df", EXP_DF);
        expectState("lda.dec", EXP_DEC);
        expectState("lda.mrd", EXP_MRD);

        // STA
        setInstr(8'h12, 5'h00, 3'b000);
        expectState("sta.if", EXP_IF);
        expectState("sta.df", EXP_DF);
        expectState("sta.dec", EXP_DEC);
        expectState("sta.mwr", EXP_MWR);

        // JMP
        setInstr(8'h20, 5'h10, 3'b000);
        expectState("jmp.if", EXP_IF);
        expectState("jmp.df", EXP_DF);
        expectState("jmp.dec", EXP_DEC);
        expectState("jmp.jmp", EXP_JMP);

        // ALU 0x61 / DI 0x0A: aluOp=2, A forced to 0
        setInstr(8'h61, 5'h0A, 3'b000);
        expectState("alu0a.if", EXP_IF);
        expectState("alu0a.df", EXP_DF);
        expectState("alu0a.dec", EXP_DEC);
        expectState("alu0a.rb", EXP_RB);
        expectState("alu0a.ex", EXP_EX0A);
        expectState("alu0a.wb", EXP_WB);

        // ALU DI 0x15: aluOp=5, B forced to 0
        setInstr(8'h6E, 5'h15, 3'b111);
        expectState("alu15.if", EXP_IF);
        expectState("alu15.df", EXP_DF);
        expectState("alu15.dec", EXP_DEC);
        expectState("alu15.rb", EXP_RB);
        expectState("alu15.ex", EXP_EX15);
        expectState("alu15.wb", EXP_WB);

        // Branches: taken goes through JMP, not taken returns after DEC
        setInstr(8'h30, 5'h00, 3'b010);
        expectState("brz1.if", EXP_IF);
        expectState("brz1.df", EXP_DF);
        expectState("brz1.dec", EXP_DEC);
        expectState("brz1.jmp", EXP_JMP);
        setInstr(8'h30, 5'h00, 3'b000);
        expectState("brz0.if", EXP_IF);
        expectState("brz0.df", EXP_DF);
        expectState("brz0.dec", EXP_DEC);
        setInstr(8'h40, 5'h00, 3'b100);
        expectState("brc1.if", EXP_IF);
        expectState("brc1.df", EXP_DF);
        expectState("brc1.dec", EXP_DEC);
        expectState("brc1.jmp", EXP_JMP);
        setInstr(8'h40, 5'h00, 3'b011);
        expectState("brc0.if", EXP_IF);
        expectState("brc0.df", EXP_DF);
        expectState("brc0.dec", EXP_DEC);
        setInstr(8'h50, 5'h00, 3'b001);
        expectState("brn1.if", EXP_IF);
        expectState("brn1.df", EXP_DF);
        expectState("brn1.dec", EXP_DEC);
        expectState("brn1.jmp", EXP_JMP);
        setInstr(8'h50, 5'h00, 3'b110);
        expectState("brn0.if", EXP_IF);
        expectState("brn0.df", EXP_DF);
        expectState("brn0.dec", EXP_DEC);

        // Reset mid-EX: result load drops at once, IF on release
        setInstr(8'h61, 5'h0A, 3'b000);
        expectState("rstex.if", EXP_IF);
        expectState("rstex.df", EXP_DF);
        expectState("rstex.dec", EXP_DEC);
        expectState("rstex.rb", EXP_RB);
        checkVal("rstex.ex", {11'd0, obsBus}, {11'd0, EXP_EX0A});
        rst = 1'b0;
        #1;
        checkVal("rstex.resload", {31'd0, aluResLoadEn}, 32'd0);
        checkVal("rstex.bus", {11'd0, obsBus}, {11'd0, EXP_IF});
        @(negedge clk);
        rst = 1'b1;
        setInstr(8'h01, 5'h00, 3'b000);
        expectState("rel.if", EXP_IF);
        expectState("rel.df", EXP_DF);
        expectState("rel.dec", EXP_DEC);
        expectState("rel.mrd", EXP_MRD);

        // Undefined opcode 9
        setInstr(8'h90, 5'h00, 3'b000);
        expectState("op9.if", EXP_IF);
        expectState("op9.df", EXP_DF);
        expectState("op9.dec", EXP_DEC);
`ifdef CTRL_ILLEGAL_TRAP_EN
        checkVal("op9.illegal", {31'd0, illegalOp}, 32'd1);
        expectState("op9.halt", EXP_HALT);
        checkVal("op9.illegalhold", {31'd0, illegalOp}, 32'd1);
        rst = 1'b0;
        #1;
        checkVal("op9.illegalclr", {31'd0, illegalOp}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
`else
        checkVal("op9.illegal", {31'd0, illegalOp}, 32'd0);
`endif

        // HLT: halted from cycle 4 and held, no enables
        setInstr(8'hF0, 5'h00, 3'b000);
        expectState("hlt.if", EXP_IF);
        expectState("hlt.df", EXP_DF);
        expectState("hlt.dec", EXP_DEC);
        for (int i = 0; i < 20; i++) begin
            setInstr(8'h10 + 8'(i), 5'(i), 3'(i));
            expectState($sformatf("hlt.hold%0d", i), EXP_HALT);
        end
        checkVal("hlt.illegal", {31'd0, illegalOp}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

    // Mutual-exclusion invariants checked on every cycle
    always @(negedge clk) begin
        if (pcInc && pcLoadEn) begin
            testsFail++;
            $display("FAIL pcExcl: pcInc=%0b pcLoadEn=%0b, want not both 1", pcInc, pcLoadEn);
        end
        if (memReadEn && memWriteEn) begin
            testsFail++;
            $display("FAIL memExcl: rd=%0b wr=%0b, want not both 1", memReadEn, memWriteEn);
        end
    end

endmodule
